// File: rtl/toggle_checker.sv
// Checks a periodically inverting word against the inverse of its last expected value.
// Optional TOGGLE_CHECKER_STABLE_EN also flags changes between compare cycles.
module toggle_checker #(
    parameter int WIDTH      = 4,
    parameter int PERIOD     = 10,
    parameter int NUM_CHECKS = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       checks
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_CYC = 16'(PERIOD - 1);
    localparam logic [7:0]  LAST_CHK = 8'(NUM_CHECKS);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [15:0]      cyc_q, cyc_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       checks_q, checks_d;
    logic             pass_q, pass_d;
`ifdef TOGGLE_CHECKER_STABLE_EN
    logic             early_q, early_d;
`endif

    logic             is_cmp;
    logic             is_last;
    logic [WIDTH-1:0] exp_word;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (c == ERR_MAX) ? c : c + 1'b1;
    endfunction

    assign is_cmp   = (cyc_q == LAST_CYC);
    assign is_last  = ((checks_q + 8'd1) == LAST_CHK);
    assign exp_word = ~ref_q;

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        cyc_d     = cyc_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        checks_d  = checks_q;
        pass_d    = pass_q;
`ifdef TOGGLE_CHECKER_STABLE_EN
        early_d   = early_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_CHECK;
                    ref_d     = value;
                    cyc_d     = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    checks_d  = '0;
                    pass_d    = 1'b0;
`ifdef TOGGLE_CHECKER_STABLE_EN
                    early_d   = 1'b0;
`endif
                end
            end
            S_CHECK: begin
                if (is_cmp) begin
                    cyc_d    = '0;
                    checks_d = checks_q + 8'd1;
                    // A mismatch still advances the expectation: one glitch, one error.
                    ref_d    = exp_word;
                    if (value != exp_word) begin
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
`ifdef TOGGLE_CHECKER_STABLE_EN
                    early_d = 1'b0;
`endif
                    if (is_last) begin
                        state_d = S_DONE;
                        pass_d  = (err_cnt_d == '0);
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
`ifdef TOGGLE_CHECKER_STABLE_EN
                    if (value != ref_q && !early_q) begin
                        early_d   = 1'b1;
                        err_d     = 1'b1;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ref_q     <= '0;
            cyc_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            checks_q  <= '0;
            pass_q    <= 1'b0;
`ifdef TOGGLE_CHECKER_STABLE_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            cyc_q     <= cyc_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            checks_q  <= checks_d;
            pass_q    <= pass_d;
`ifdef TOGGLE_CHECKER_STABLE_EN
            early_q   <= early_d;
`endif
        end
    end

    assign busy    = (state_q == S_CHECK);
    assign done    = (state_q == S_DONE);
    assign pass    = pass_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign checks  = checks_q;

endmodule

// File: tb/tb_toggle_checker.sv
// Directed bench for toggle_checker: default instance plus a short-period,
// 1-bit-counter instance that exercises counter saturation.
module tb_toggle_checker;

`ifdef TOGGLE_CHECKER_STABLE_EN
    localparam int TG = 9;
`else
    localparam int TG = 5;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] value;

    logic       busy_a, done_a, pass_a, err_a;
    logic [7:0] err_cnt_a, checks_a;
    logic       busy_b, done_b, pass_b, err_b;
    logic [0:0] err_cnt_b;
    logic [7:0] checks_b;

    int n_checks = 0;
    int n_err    = 0;
    int cn       = 0;

    toggle_checker dut_a (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err(err_a),
        .err_cnt(err_cnt_a), .checks(checks_a)
    );

    toggle_checker #(.WIDTH(4), .PERIOD(2), .NUM_CHECKS(3), .ERR_W(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err(err_b),
        .err_cnt(err_cnt_b), .checks(checks_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cn++;
    endtask

    task automatic run_to(input int n);
        while (cn < n) tick();
    endtask

    task automatic do_start(input logic [3:0] v);
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        cn = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = 4'h0;
        repeat (3) tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_cnt", 32'(err_cnt_a), 32'd0);
        check("rst_checks", 32'(checks_a), 32'd0);
        reset = 1'b0;
        tick();

        // clean run
        do_start(4'hA);
        check("t1_busy", 32'(busy_a), 32'd1);
        run_to(TG);
        value = 4'h5;
        run_to(10);
        check("t1_checks1", 32'(checks_a), 32'd1);
        check("t1_err_mid", 32'(err_a), 32'd0);
        run_to(TG + 10);
        value = 4'hA;
        run_to(19);
        check("t1_done19", 32'(done_a), 32'd0);
        run_to(20);
        check("t1_done", 32'(done_a), 32'd1);
        check("t1_busy_end", 32'(busy_a), 32'd0);
        check("t1_pass", 32'(pass_a), 32'd1);
        check("t1_err", 32'(err_a), 32'd0);
        check("t1_cnt", 32'(err_cnt_a), 32'd0);
        check("t1_checks", 32'(checks_a), 32'd2);

        // restart from DONE; second compare stuck at 5
        do_start(4'hA);
        check("t2_busy", 32'(busy_a), 32'd1);
        check("t2_done_clr", 32'(done_a), 32'd0);
        run_to(TG);
        value = 4'h5;
        run_to(20);
        check("t2_done", 32'(done_a), 32'd1);
        check("t2_pass", 32'(pass_a), 32'd0);
        check("t2_err", 32'(err_a), 32'd1);
        check("t2_cnt", 32'(err_cnt_a), 32'd1);
        check("t2_checks", 32'(checks_a), 32'd2);

        // constant 3: expect C (miss), then 3 (hit) since the expectation advances
        do_start(4'h3);
        run_to(6);
        check("t3b_done", 32'(done_b), 32'd1);
        check("t3b_checks", 32'(checks_b), 32'd3);
        check("t3b_cnt_sat", 32'(err_cnt_b), 32'd1);
        check("t3b_pass", 32'(pass_b), 32'd0);
        run_to(10);
        check("t3_cnt_mid", 32'(err_cnt_a), 32'd1);
        run_to(20);
        check("t3_done", 32'(done_a), 32'd1);
        check("t3_pass", 32'(pass_a), 32'd0);
`ifdef TOGGLE_CHECKER_STABLE_EN
        check("t3_cnt", 32'(err_cnt_a), 32'd2);
`else
        check("t3_cnt", 32'(err_cnt_a), 32'd1);
`endif

        // reset mid-run
        do_start(4'hA);
        run_to(6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_busy", 32'(busy_a), 32'd0);
        check("t4_done", 32'(done_a), 32'd0);
        check("t4_cnt", 32'(err_cnt_a), 32'd0);
        check("t4_checks", 32'(checks_a), 32'd0);
        tick();
        check("t4_idle", 32'(busy_a), 32'd0);
        do_start(4'hA);
        run_to(TG);
        value = 4'h5;
        run_to(TG + 10);
        value = 4'hA;
        run_to(20);
        check("t4_done2", 32'(done_a), 32'd1);
        check("t4_pass2", 32'(pass_a), 32'd1);

        // start during CHECK is ignored
        do_start(4'hA);
        run_to(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(TG);
        value = 4'h5;
        run_to(TG + 10);
        value = 4'hA;
        run_to(19);
        check("t5_done19", 32'(done_a), 32'd0);
        check("t5_checks19", 32'(checks_a), 32'd1);
        run_to(20);
        check("t5_done", 32'(done_a), 32'd1);
        check("t5_pass", 32'(pass_a), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_rebusy", 32'(busy_a), 32'd1);
        check("t5_redone", 32'(done_a), 32'd0);

        // one-clock glitch between compares
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        do_start(4'hA);
        run_to(2);
        value = 4'hF;
        tick();
        value = 4'hA;
        run_to(9);
        value = 4'h5;
        run_to(19);
        value = 4'hA;
        run_to(20);
        check("t6_done", 32'(done_a), 32'd1);
`ifdef TOGGLE_CHECKER_STABLE_EN
        check("t6_cnt", 32'(err_cnt_a), 32'd1);
        check("t6_pass", 32'(pass_a), 32'd0);
`else
        check("t6_cnt", 32'(err_cnt_a), 32'd0);
        check("t6_pass", 32'(pass_a), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
